// File: rtl/tri_setup.sv
// Per-triangle setup: latches a vertex set in vertical blank, computes the three edge-function
// values at pixel (0,0) with a shift-add multiplier, then steps them once per visible line.
// Optional back-face culling is enabled by defining TRI_SETUP_BACKFACE_CULL_EN.
module tri_setup #(
  parameter int W  = 20,
  parameter int CW = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic signed [CW-1:0] x_v0,
  input  logic signed [CW-1:0] y_v0,
  input  logic signed [CW-1:0] x_v1,
  input  logic signed [CW-1:0] y_v1,
  input  logic signed [CW-1:0] x_v2,
  input  logic signed [CW-1:0] y_v2,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W-1:0]         y_screen_v0,
  output logic [W-1:0]         y_screen_v1,
  output logic [W-1:0]         y_screen_v2,
  output logic [W-1:0]         e0_init_t1,
  output logic [W-1:0]         e1_init_t1,
  output logic [W-1:0]         e2_init_t1,
  output logic                 busy,
  output logic                 culled
);

  localparam int PW = CW + 1;  // width of a vertex difference

  typedef enum logic [1:0] {ST_IDLE, ST_DIFF, ST_MUL, ST_DONE} state_t;

  state_t               state;
  logic signed [CW-1:0] sx [3];
  logic signed [CW-1:0] sy [3];
  logic signed [PW-1:0] a_r [3];
  logic signed [PW-1:0] b_r [3];
  logic signed [PW-1:0] da [3];
  logic signed [PW-1:0] db [3];
  logic [W-1:0]         acc [3];
  logic [W-1:0]         base_r [3];
  logic [W-1:0]         bstep [3];
  logic [W-1:0]         e_r [3];
  logic [W-1:0]         ys_r [3];
  logic [W-1:0]         mc, next_mc;
  logic [PW-1:0]        mp, next_mp;
  logic [2:0]           prod, nxt;
  logic [1:0]           idx;
  logic [3:0]           bit_cnt;

  function automatic logic [W-1:0] sext_c(input logic signed [CW-1:0] v);
    return {{(W-CW){v[CW-1]}}, v};
  endfunction

  function automatic logic [W-1:0] sext_p(input logic signed [PW-1:0] v);
    return {{(W-PW){v[PW-1]}}, v};
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      da[i] = {sy[(i+1)%3][CW-1], sy[(i+1)%3]} - {sy[i][CW-1], sy[i]};
      db[i] = {sx[(i+1)%3][CW-1], sx[(i+1)%3]} - {sx[i][CW-1], sx[i]};
    end
    // Product order: x0*a0 (negated), y0*b0, x1*a1 (negated), y1*b1, ...
    nxt     = prod + 3'd1;
    idx     = (nxt > 3'd5) ? 2'd0 : nxt[2:1];
    next_mc = nxt[0] ? sext_c(sy[idx]) : (W'(0) - sext_c(sx[idx]));
    next_mp = nxt[0] ? b_r[idx] : a_r[idx];
  end

  assign in_ready = (state == ST_IDLE) && (y == 10'd480) && (x == 10'd0);
  assign busy     = (state != ST_IDLE);

`ifdef TRI_SETUP_BACKFACE_CULL_EN
  logic         culled_r;
  logic [W-1:0] sum_s;
  // The sum of the bases is -2*area; positive means clockwise, i.e. back-facing.
  always_comb sum_s = acc[0] + acc[1] + acc[2];
  assign culled = culled_r;
`else
  assign culled = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      mc      <= '0;
      mp      <= '0;
      prod    <= '0;
      bit_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        sx[i] <= '0;  sy[i] <= '0;
        a_r[i] <= '0; b_r[i] <= '0;
        acc[i] <= '0; base_r[i] <= '0; bstep[i] <= '0;
        e_r[i] <= '0; ys_r[i] <= '0;
      end
`ifdef TRI_SETUP_BACKFACE_CULL_EN
      culled_r <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (in_valid && in_ready) begin
          sx[0] <= x_v0; sy[0] <= y_v0;
          sx[1] <= x_v1; sy[1] <= y_v1;
          sx[2] <= x_v2; sy[2] <= y_v2;
          state <= ST_DIFF;
        end
        ST_DIFF: begin
          for (int i = 0; i < 3; i++) begin
            a_r[i] <= da[i];
            b_r[i] <= db[i];
            acc[i] <= '0;
          end
          mc      <= W'(0) - sext_c(sx[0]);
          mp      <= da[0];
          prod    <= '0;
          bit_cnt <= '0;
          state   <= ST_MUL;
        end
        ST_MUL: begin
          // Radix-2 signed multiply: the multiplier's top bit carries negative weight.
          if (mp[0])
            acc[prod[2:1]] <= acc[prod[2:1]] + ((bit_cnt == 4'(PW-1)) ? (W'(0) - mc) : mc);
          if (bit_cnt == 4'(PW-1)) begin
            bit_cnt <= '0;
            if (prod == 3'd5) begin
              state <= ST_DONE;
            end else begin
              prod <= nxt;
              mc   <= next_mc;
              mp   <= next_mp;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            mc      <= mc << 1;
            mp      <= mp >> 1;
          end
        end
        ST_DONE: begin
          for (int i = 0; i < 3; i++) begin
            base_r[i] <= acc[i];
            bstep[i]  <= sext_p(b_r[i]);
            ys_r[i]   <= sext_c(sy[i]);
          end
`ifdef TRI_SETUP_BACKFACE_CULL_EN
          culled_r <= 1'b0;
          // Mixed-sign constant edges make every pixel fail the inside test.
          if ($signed(sum_s) > 0) begin
            culled_r  <= 1'b1;
            base_r[0] <= W'(1);
            base_r[1] <= '1;
            base_r[2] <= '1;
            for (int i = 0; i < 3; i++) begin
              bstep[i] <= '0;
              ys_r[i]  <= '0;
            end
          end
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Reload for line 0 at the end of blank; otherwise prepare line y+1 at the start of line y.
      for (int i = 0; i < 3; i++) begin
        if (y == 10'd524 && x == 10'd0)
          e_r[i] <= base_r[i];
        else if (x == 10'd0 && y <= 10'd478)
          e_r[i] <= e_r[i] - bstep[i];
      end
    end
  end

  assign y_screen_v0 = ys_r[0];
  assign y_screen_v1 = ys_r[1];
  assign y_screen_v2 = ys_r[2];
  assign e0_init_t1  = e_r[0];
  assign e1_init_t1  = e_r[1];
  assign e2_init_t1  = e_r[2];

endmodule

// File: tb/tb_tri_setup.sv
// Scoreboard bench for tri_setup: stimulus queues expected outputs, monitors compare them.
// Expectations for the culling case follow TRI_SETUP_BACKFACE_CULL_EN.
module tb_tri_setup;
  localparam int W  = 20;
  localparam int CW = 11;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [9:0]           x, y;
  logic signed [CW-1:0] x_v0, y_v0, x_v1, y_v1, x_v2, y_v2;
  logic                 in_valid;
  logic                 in_ready, busy, culled;
  logic [W-1:0]         y_screen_v0, y_screen_v1, y_screen_v2;
  logic [W-1:0]         e0_init_t1, e1_init_t1, e2_init_t1;

  tri_setup #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .x_v0(x_v0), .y_v0(y_v0), .x_v1(x_v1), .y_v1(y_v1), .x_v2(x_v2), .y_v2(y_v2),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_screen_v0(y_screen_v0), .y_screen_v1(y_screen_v1), .y_screen_v2(y_screen_v2),
    .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
    .busy(busy), .culled(culled)
  );

  always #5 clk = ~clk;

  typedef logic [2:0][W-1:0] tri_t;
  typedef struct packed {
    tri_t e;
    tri_t ys;
    logic cul;
    logic bsy;
    logic rdy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    busy_q[$];
  int    total = 0;
  int    bad   = 0;
  logic  probe = 1'b0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  function automatic tri_t mk3(input int a, input int b, input int c);
    tri_t t;
    t[0] = W'(a);
    t[1] = W'(b);
    t[2] = W'(c);
    return t;
  endfunction

  function automatic exp_t mkexp(input tri_t e, input tri_t ys, input logic c, input logic r);
    exp_t ex;
    ex.e   = e;
    ex.ys  = ys;
    ex.cul = c;
    ex.bsy = 1'b0;
    ex.rdy = r;
    return ex;
  endfunction

  // Triangle A edge model: value loaded for line L is base - L*b.
  function automatic tri_t line_a(input int l);
    return mk3(-25000 - l * 200, -100000 + l * 250, 37500 - l * 50);
  endfunction

  // Output monitor: compares everything against the queued expectation when probed.
  exp_t  ex;
  string nm;
  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        check("probe_without_expectation", W'(1), W'(0));
      end else begin
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_in_ready"}, W'(in_ready), W'(ex.rdy));
        check({nm, "_busy"}, W'(busy), W'(ex.bsy));
        check({nm, "_culled"}, W'(culled), W'(ex.cul));
        check({nm, "_e0"}, e0_init_t1, ex.e[0]);
        check({nm, "_e1"}, e1_init_t1, ex.e[1]);
        check({nm, "_e2"}, e2_init_t1, ex.e[2]);
        check({nm, "_ys0"}, y_screen_v0, ex.ys[0]);
        check({nm, "_ys1"}, y_screen_v1, ex.ys[1]);
        check({nm, "_ys2"}, y_screen_v2, ex.ys[2]);
      end
    end
  end

  // Busy monitor: measures each busy run; runs cut by reset are discarded.
  int run = 0;
  bit aborted = 1'b0;
  always @(negedge clk) begin
    if (busy) begin
      run++;
      if (reset) aborted = 1'b1;
    end else if (run > 0) begin
      if (reset) aborted = 1'b1;
      if (!aborted) begin
        if (busy_q.size() == 0) check("busy_unexpected", W'(run), W'(0));
        else check("busy_len", W'(run), W'(busy_q.pop_front()));
      end
      run = 0;
      aborted = 1'b0;
    end
  end

  task automatic tick(input int yy, input int xx);
    y = 10'(yy);
    x = 10'(xx);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input string n, input int yy, input int xx, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
    probe = 1'b1;
    tick(yy, xx);
    probe = 1'b0;
  endtask

  task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy);
    x_v0 = CW'(ax); y_v0 = CW'(ay);
    x_v1 = CW'(bx); y_v1 = CW'(by);
    x_v2 = CW'(cx); y_v2 = CW'(cy);
  endtask

  tri_t z3, ys_a, ea, ea479, ys_b, eb0, eb1;
  logic cul_b;

  initial begin
    z3    = mk3(0, 0, 0);
    ys_a  = mk3(50, 400, 400);
    ea    = mk3(-25000, -100000, 37500);
    ea479 = mk3(-120800, 19750, 13550);
`ifdef TRI_SETUP_BACKFACE_CULL_EN
    cul_b = 1'b1;
    ys_b  = z3;
    eb0   = mk3(1, -1, -1);
    eb1   = mk3(1, -1, -1);
`else
    cul_b = 1'b0;
    ys_b  = mk3(50, 400, 400);
    eb0   = mk3(-37500, 100000, 25000);
    eb1   = mk3(-37450, 99750, 25200);
`endif

    reset    = 1'b1;
    in_valid = 1'b0;
    set_tri(100, 50, 300, 400, 50, 400);
    x = '0;
    y = '0;
    repeat (3) tick(0, 0);
    reset = 1'b0;
    expect_at("por", 480, 1, mkexp(z3, z3, 1'b0, 1'b0));

    // Transfer, then abort with reset mid-multiply.
    in_valid = 1'b1;
    expect_at("rdy_first", 480, 0, mkexp(z3, z3, 1'b0, 1'b1));
    in_valid = 1'b0;
    for (int k = 1; k <= 30; k++) tick(480, k);
    reset = 1'b1;
    repeat (3) tick(480, 40);
    reset = 1'b0;
    expect_at("rst_mid", 480, 41, mkexp(z3, z3, 1'b0, 1'b0));
    expect_at("rst_idle_rdy", 480, 0, mkexp(z3, z3, 1'b0, 1'b1));
    tick(524, 0);
    expect_at("rst_reload", 524, 1, mkexp(z3, z3, 1'b0, 1'b0));

    // Triangle A.
    in_valid = 1'b1;
    busy_q.push_back(74);
    expect_at("rdy_a", 480, 0, mkexp(z3, z3, 1'b0, 1'b1));
    in_valid = 1'b0;
    for (int k = 1; k <= 80; k++) tick(480, k);
    expect_at("done_a", 481, 0, mkexp(z3, ys_a, 1'b0, 1'b0));
    tick(524, 0);
    expect_at("line0_a", 524, 1, mkexp(ea, ys_a, 1'b0, 1'b0));
    tick(0, 0);
    expect_at("line1_a", 0, 1, mkexp(mk3(-25200, -99750, 37450), ys_a, 1'b0, 1'b0));
    for (int l = 1; l <= 239; l++) tick(l, 0);
    expect_at("line240_a", 239, 1, mkexp(line_a(240), ys_a, 1'b0, 1'b0));
    for (int l = 240; l <= 478; l++) tick(l, 0);
    expect_at("line479_a", 478, 1, mkexp(ea479, ys_a, 1'b0, 1'b0));
    tick(479, 0);
    expect_at("rdy_novalid", 480, 0, mkexp(ea479, ys_a, 1'b0, 1'b1));
    tick(500, 0);
    tick(523, 0);
    expect_at("hold_a", 523, 1, mkexp(ea479, ys_a, 1'b0, 1'b0));
    tick(524, 0);
    expect_at("reload_a", 524, 1, mkexp(ea, ys_a, 1'b0, 1'b0));

    // Valid only off the handshake point: must be ignored.
    set_tri(100, 50, 50, 400, 300, 400);
    in_valid = 1'b1;
    expect_at("rdy_x1", 480, 1, mkexp(ea, ys_a, 1'b0, 1'b0));
    in_valid = 1'b0;
    for (int k = 2; k <= 80; k++) tick(480, k);
    expect_at("keep_a", 481, 0, mkexp(ea, ys_a, 1'b0, 1'b0));

    // Triangle B: A with v1 and v2 swapped (back-facing).
    in_valid = 1'b1;
    busy_q.push_back(74);
    expect_at("rdy_b", 480, 0, mkexp(ea, ys_a, 1'b0, 1'b1));
    in_valid = 1'b0;
    for (int k = 1; k <= 80; k++) tick(480, k);
    expect_at("done_b", 481, 0, mkexp(ea, ys_b, cul_b, 1'b0));
    tick(524, 0);
    expect_at("line0_b", 524, 1, mkexp(eb0, ys_b, cul_b, 1'b0));
    tick(0, 0);
    expect_at("line1_b", 0, 1, mkexp(eb1, ys_b, cul_b, 1'b0));

    repeat (3) tick(481, 5);
    check("busy_q_left", W'(busy_q.size()), W'(0));
    check("exp_q_left", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
